div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 42 ++++
 rtl/div_unit.sv | 185 ++++++++++++++++++
 tb/tb_div_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if -- request/result bundle between the execute stage and div_unit.
//
// Handshake: the requester raises start with opa/opb/signed_div valid and keeps
// it high while stall is high. The divider accepts the request in the cycle it
// is idle, start=1 and cancel=0. It samples the operands only in that cycle and
// holds stall until the divide is about to finish. Completion is a single-cycle
// ready pulse, and result is valid in that cycle. The divider holds result until
// the next completion. The requester has no way to refuse ready, and the
// divider applies no back-pressure other than stall.
//
// Signals (WIDTH = operand width):
//   start       requester -> divider  divide request (level, held while stalled)
//   signed_div  requester -> divider  1 = signed divide, 0 = unsigned
//   opa, opb    requester -> divider  dividend, divisor
//   cancel      requester -> divider  flush; aborts an accepted or pending divide
//   stall       divider -> requester  pipeline freeze request
//   ready       divider -> requester  one-cycle completion pulse
//   result      divider -> requester  {hi = remainder, lo = quotient}
// -----------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               cancel;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, opa, opb, cancel,
    input  stall, ready, result
  );

  modport slave (
    input  start, signed_div, opa, opb, cancel,
    output stall, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle restoring radix-2 integer divider for the HI/LO path.
//
// The divider computes one quotient bit per cycle, starting with the MSB. A
// WIDTH-bit divide takes WIDTH RUN cycles. The design then spends one DONE
// cycle on sign correction and on registering the result.
//
// The DONE cycle loads result and raises the ready pulse at the same edge. The
// pulse is therefore visible in the cycle after DONE. A cancel seen in DONE
// still blocks both the result update and the pulse.
//
// A zero divisor skips RUN and gives lo = all ones and hi = opa. The signed case
// most-negative / -1 wraps naturally to lo = most-negative and hi = 0.
//
// Optional feature: define DIV_SIGNED_EN to honour signed_div. When the macro
// is not defined, every divide is unsigned and no sign logic is built.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   bus          div_unit_if slave modport (start/operands/cancel in,
//                stall/ready/result out)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
// The WIDTH parameter must match the WIDTH of the connected interface.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_unit_if.slave       bus,
  output logic [1:0]      dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor magnitude
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     fin_lo, fin_hi;
  logic [WIDTH:0]       shifted, diff;

  assign accept = (state_q == IDLE) && bus.start && !bus.cancel;

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign sign_a = bus.signed_div & bus.opa[WIDTH-1];
  assign sign_b = bus.signed_div & bus.opb[WIDTH-1];
  assign mag_a  = sign_a ? (~bus.opa + WIDTH'(1)) : bus.opa;
  assign mag_b  = sign_b ? (~bus.opb + WIDTH'(1)) : bus.opb;

  // Sign flags are captured at acceptance. A zero divisor returns opa
  // unmodified, so both flags are forced clear in that case.
  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      neg_quo_d = (bus.opb != '0) && (sign_a ^ sign_b);
      neg_rem_d = (bus.opb != '0) && sign_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign fin_lo = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign fin_hi = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
`else
  logic unused_signed_div;

  assign unused_signed_div = bus.signed_div;
  assign mag_a  = bus.opa;
  assign mag_b  = bus.opb;
  assign fin_lo = quo_q;
  assign fin_hi = rem_q;
`endif

  // Restoring step: bring the next dividend bit into the remainder, then
  // subtract the divisor. Diff bit WIDTH set means the trial went negative.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          dvs_d = mag_b;
          if (bus.opb == '0) begin
            quo_d   = '1;
            rem_d   = bus.opa;
            state_d = DONE;
          end else begin
            quo_d   = mag_a;
            rem_d   = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          // The counter holds at WIDTH-1 rather than wrapping.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          result_d = {fin_hi, fin_lo};
          ready_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.stall   = accept || (state_q == RUN);
  assign bus.ready   = ready_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit (WIDTH = 32).
// Expected quotients, remainders and latencies are worked out by hand.
// Signed expectations depend on whether DIV_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  dbg_state;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_exp = '0;

  div_unit_if #(.WIDTH(W)) bus();

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  // --------------------------------------------------------------- driver tasks
  // Issue one divide the way the pipeline would. start stays high while stall
  // is high, and the operands are scrambled after the start cycle. The task
  // reports the edge index (start sampled at edge 0) on which ready was seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic sd, output logic [63:0] res,
                         output int lat, output int stall_cnt);
    lat       = -1;
    stall_cnt = 0;
    res       = '0;
    @(negedge clk);
    bus.opa        = a;
    bus.opb        = b;
    bus.signed_div = sd;
    bus.cancel     = 1'b0;
    bus.start      = 1'b1;
    #1 if (bus.stall) stall_cnt++;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat = cyc - 1;
        res = bus.result;
        break;
      end
      if (bus.start && !bus.stall) begin
        bus.start = 1'b0;
      end else begin
        bus.opa        = $urandom;
        bus.opb        = $urandom;
        bus.signed_div = 1'($urandom_range(0, 1));
      end
      #1 if (bus.stall) stall_cnt++;
    end
    bus.start = 1'b0;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    bus.start = 1'b0; bus.cancel = 1'b0; bus.signed_div = 1'b0;
    bus.opa = '0; bus.opb = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    checks++;
    if (bus.result !== 64'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", bus.result);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] ta [5] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF, 32'hFFFF_FFF9};
    logic [31:0] tb [5] = '{32'd7,   32'h10,        32'd9, 32'd1,        32'd2};
    logic [63:0] te [5] = '{{32'd2, 32'd14}, {32'hF, 32'h0FFF_FFFF}, {32'd5, 32'd0},
                            {32'd0, 32'hDEAD_BEEF}, {32'd1, 32'h7FFF_FFFC}};
    logic [63:0] res;
    int lat, sc;
    for (int i = 0; i < 5; i++) begin
      run_div(ta[i], tb[i], 1'b0, res, lat, sc);
      checks++;
      if (res !== te[i]) begin
        errors++; $display("FAIL unsigned_result[%0d]: got %h expected %h", i, res, te[i]);
      end
      checks++;
      if (lat !== 33) begin
        errors++; $display("FAIL unsigned_latency[%0d]: got %0d expected 33", i, lat);
      end
      last_exp = te[i];
      if (i == 0) begin
        checks++;
        if (sc !== 33) begin
          errors++; $display("FAIL unsigned_stall_cycles: got %0d expected 33", sc);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
          errors++; $display("FAIL ready_one_cycle: got %b expected 0", bus.ready);
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
          errors++; $display("FAIL start_ignored_in_done: got state %0d expected %0d", dbg_state, S_IDLE);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,         32'hFFFF_FFF9, 32'd100};
    logic [31:0] tb [5] = '{32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7};
`ifdef DIV_SIGNED_EN
    logic [63:0] te [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000},
                            {32'd1, 32'hFFFF_FFFD}, {32'hFFFF_FFFF, 32'd3}, {32'd2, 32'd14}};
`else
    logic [63:0] te [5] = '{{32'd1, 32'h7FFF_FFFC}, {32'h8000_0000, 32'h0},
                            {32'd7, 32'd0}, {32'hFFFF_FFF9, 32'd0}, {32'd2, 32'd14}};
`endif
    logic [63:0] res;
    int lat, sc;
    for (int i = 0; i < 5; i++) begin
      run_div(ta[i], tb[i], 1'b1, res, lat, sc);
      checks++;
      if (res !== te[i]) begin
        errors++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, te[i]);
      end
      last_exp = te[i];
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int lat, sc;
    run_div(32'h1234_5678, 32'd0, 1'b0, res, lat, sc);
    checks++;
    if (res !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL divzero_result: got %h expected 12345678ffffffff", res);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL divzero_latency: got %0d expected 1", lat);
    end
    checks++;
    if (sc !== 1) begin
      errors++; $display("FAIL divzero_stall_cycles: got %0d expected 1", sc);
    end
    run_div(32'h8000_0001, 32'd0, 1'b1, res, lat, sc);
    checks++;
    if (res !== {32'h8000_0001, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL divzero_signed_result: got %h expected 80000001ffffffff", res);
    end
    last_exp = {32'h8000_0001, 32'hFFFF_FFFF};
  endtask

  task automatic test_cancel_run();
    bit seen = 1'b0;
    @(negedge clk);
    bus.opa = 32'd1000; bus.opb = 32'd3; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (11) @(negedge clk);   // cycle after edge 10: RUN cycle 10
    checks++;
    if (dbg_state !== S_RUN) begin
      errors++; $display("FAIL cancel_pre_state: got %0d expected %0d", dbg_state, S_RUN);
    end
    bus.cancel = 1'b1;
    bus.start  = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++; $display("FAIL cancel_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL cancel_stall: got %b expected 0", bus.stall);
    end
    bus.cancel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL cancel_no_ready: got %b expected 0", seen);
    end
    checks++;
    if (bus.result !== last_exp) begin
      errors++; $display("FAIL cancel_result_kept: got %h expected %h", bus.result, last_exp);
    end
  endtask

  task automatic test_cancel_done();
    bit seen = 1'b0;
    @(negedge clk);
    bus.opa = 32'h0BAD_F00D; bus.opb = 32'd0; bus.signed_div = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_DONE) begin
      errors++; $display("FAIL cancel_done_state: got %0d expected %0d", dbg_state, S_DONE);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL done_stall: got %b expected 0", bus.stall);
    end
    bus.cancel = 1'b1;
    bus.start  = 1'b0;
    @(negedge clk);
    bus.cancel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ready) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL cancel_done_no_ready: got %b expected 0", seen);
    end
    checks++;
    if (bus.result !== last_exp) begin
      errors++; $display("FAIL cancel_done_result: got %h expected %h", bus.result, last_exp);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    logic [63:0] res;
    int lat, sc;
    @(negedge clk);
    bus.opa = 32'd123456; bus.opb = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    repeat (6) @(negedge clk);    // RUN cycle 5
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    checks++;
    if (bus.result !== 64'h0) begin
      errors++; $display("FAIL midrst_result: got %h expected 0", bus.result);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready: got %b expected 0", bus.ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_no_ready: got %b expected 0", seen);
    end
    run_div(32'd9, 32'd3, 1'b0, res, lat, sc);
    checks++;
    if (res !== {32'd0, 32'd3}) begin
      errors++; $display("FAIL midrst_followup: got %h expected 0000000000000003", res);
    end
    last_exp = {32'd0, 32'd3};
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, sc;
    run_div(32'd1000, 32'd3, 1'b0, res, lat, sc);
    checks++;
    if (res !== {32'd1, 32'd333}) begin
      errors++; $display("FAIL b2b_first: got %h expected %h", res, {32'd1, 32'd333});
    end
    run_div(32'h0000_FFFF, 32'h0000_00FF, 1'b0, res, lat, sc);
    checks++;
    if (res !== {32'd0, 32'h101}) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", res, {32'd0, 32'h101});
    end
    last_exp = {32'd0, 32'h101};
    repeat (5) @(negedge clk);
    checks++;
    if (bus.result !== last_exp) begin
      errors++; $display("FAIL result_hold: got %h expected %h", bus.result, last_exp);
    end
  endtask

  // ------------------------------------------------------------------ sequence
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel_run();
    test_cancel_done();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
